// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the multicycle main controller:
//                state encodings, instruction-class codes and the
//                datapath mux select values.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Main controller states; codes 11-15 are unused.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    // Instruction class, Instr[27:26]; 2'b11 is undefined.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/main_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : main_ctrl_outdec
//  Description : Pure state-to-output decode for the main controller.
//                Illegal state codes decode to all-zero outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp
);

    // Moore decode: every output is a function of the state only.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
            end
            S_DECODE: begin
                // PC+8 is formed here for use as R15 in later states.
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR: begin
                ALUSrcB   = SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            S_EXECUTER: begin
                ALUOp     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB   = SRCB_IMM;
                ALUOp     = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                Branch    = 1'b1;
            end
            default: begin
                // S_UNKNOWN and unreachable codes keep the all-zero defaults.
            end
        endcase
    end

endmodule : main_ctrl_outdec
`default_nettype wire

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_ctrl_fsm
//  Description : Multicycle main control FSM. Sequences each instruction
//                through fetch/decode/execute/memory/writeback and issues
//                the unconditioned write requests for the condition logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic [STATE_W-1:0] State
);

    state_t r_state;
    state_t w_stateNext;

    // Funct[4:1] belong to the ALU decoder, not to sequencing.
    logic w_unusedFunct;
    assign w_unusedFunct = ^Funct[4:1];

    // State register; reset drops straight back to FETCH, abandoning any
    // write that was pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; Op/Funct are only looked at in DECODE and MEMADR.
    always_comb begin
        w_stateNext = S_FETCH;
        case (r_state)
            S_FETCH:    w_stateNext = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  w_stateNext = S_MEMADR;
                    OP_DP:   w_stateNext = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   w_stateNext = S_BRANCH;
                    default: w_stateNext = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   w_stateNext = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_stateNext = S_MEMWB;
            S_EXECUTER: w_stateNext = S_ALUWB;
            S_EXECUTEI: w_stateNext = S_ALUWB;
            default:    w_stateNext = S_FETCH;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state     (r_state),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp)
    );

    assign State = STATE_W'(r_state);

endmodule : main_ctrl_fsm
`default_nettype wire

// File: doc/main_ctrl_fsm.md
Name: main_ctrl_fsm

Overview:
- Multicycle main control state machine. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It produces the unconditioned write requests (NextPC, RegW, MemW, Branch) that the condition-logic block gates with the registered condition result to form PCWrite, RegWrite and MemWrite.
- It also drives the datapath mux selects, IRWrite and ALUOp.
- It sits in the controller beside the ALU/PC decoders.

Parameters:
- STATE_W, 4, width of the state register and the debug state port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Op  input  2  instruction class, Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  input  6  Instr[25:20]; bit5 = immediate, bit0 = load/S.
- IRWrite  output  1  instruction register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  output  1  1 = PC, 0 = register A.
- ALUSrcB  output  2  00 = register B, 01 = extended immediate, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  output  1  unconditional PC write request.
- RegW  output  1  register write request, before the condition gate.
- MemW  output  1  memory write request, before the condition gate.
- Branch  output  1  conditional PC write request.
- ALUOp  output  1  1 = ALU decoder uses Funct, 0 = add.
- State  output  STATE_W  current state, for debug and verification.

Behaviour:
- Moore machine. All outputs are a pure decode of the state register; there is no input-to-output combinational path.
- Reset is asynchronous and active-low. While reset=0, the state is FETCH and the outputs show FETCH values (IRWrite=1, NextPC=1). Downstream PC/IR registers are also held in reset.
- Reset asserted mid-instruction forces FETCH immediately, with no completion of the pending write.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10
  - Codes 11-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD; else -> MEMWR.
  - MEMRD->MEMWB->FETCH. MEMWR->FETCH.
  - EXECUTER->ALUWB and EXECUTEI->ALUWB; ALUWB->FETCH.
  - BRANCH->FETCH. UNKNOWN->FETCH.
- Outputs per state. Any output not listed is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all 0.
- Latencies from FETCH back to FETCH: LDR 5 cycles, STR 4, data-processing 4, branch 3, undefined 3.
- Interface contract with the condition logic:
  - That block registers CondEx every cycle.
  - RegW, MemW and Branch are therefore never asserted in FETCH or DECODE. Each is asserted for exactly one cycle per instruction, at least two cycles after FETCH.
  - NextPC is asserted only in FETCH.
- At most one of {RegW, MemW, Branch} is high in any cycle. IRWrite and NextPC are high together only in FETCH.
- Op/Funct are sampled only in DECODE and MEMADR; changes in other states have no effect.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state encodings;
  - OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10;
  - SRCB_REG/SRCB_IMM/SRCB_FOUR;
  - RES_ALUOUT/RES_DATA/RES_ALU.
- One sub-module, main_ctrl_outdec: purely combinational state-to-output decoder.
- State register and next-state logic stay in main_ctrl_fsm.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-EXECUTER, then release -> State=0, IRWrite=1, NextPC=1 during reset; first edge after release gives State=1.
- LDR (Op=01, Funct=6'b011001) -> State sequence 0,1,2,3,4,0; RegW=1 only in state 4 with ResultSrc=01; MemW never asserted.
- STR (Op=01, Funct=6'b011000) -> sequence 0,1,2,5,0; MemW=1 only in state 5 with AdrSrc=1; RegW stays 0.
- ADD register (Op=00, Funct=6'b001000) then ADD immediate (Funct=6'b101000) -> sequences 0,1,6,8,0 then 0,1,7,8,0; ALUOp=1 in states 6/7; ALUSrcB=00 in state 6 and 01 in state 7.
- B (Op=10), then Op=11 -> sequences 0,1,9,0 with Branch=1 in state 9, then 0,1,10,0 with all outputs 0 in state 10.
- Toggle Op/Funct randomly in non-sampling states, with an assertion checker -> sequences unchanged; RegW/MemW/Branch never high in states 0/1; at most one of the three high per cycle.
